// File: rtl/req_gnt_pkg.sv
// Shared types and helpers for the round-robin request/grant scheduler.
package req_gnt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StGrant
  } sched_state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/req_gnt_scheduler_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, else wrap to bit 0.
module rr_pick
  import req_gnt_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [id_width(NUM_REQ)-1:0]    ptr,
  output logic [id_width(NUM_REQ)-1:0]    idx,
  output logic                            found
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Upper pass from the pointer, then the wrapped lower pass.
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (IdW'(j) >= ptr)) begin
        found = 1'b1;
        idx   = IdW'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IdW'(j);
      end
    end
  end

endmodule

// File: rtl/req_gnt_scheduler.sv
// Round-robin scheduler: accepts one request in IDLE and pulses its one-hot grant
// exactly GNT_DELAY clocks later; counts requests rejected while a grant is pending.
module req_gnt_scheduler
  import req_gnt_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned GNT_DELAY = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enb,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          busy,
  output logic [id_width(NUM_REQ)-1:0]  gnt_id,
  output logic [CNT_W-1:0]              rej_cnt
);

  localparam int unsigned IdW = id_width(NUM_REQ);
  localparam int unsigned DW  = id_width(GNT_DELAY);
  // Acceptance edge plus DLoad+1 WAIT edges puts the gnt set at T+GNT_DELAY-1.
  localparam logic [DW-1:0] DLoad = DW'(GNT_DELAY - 2);

  sched_state_e       state_q, state_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [IdW-1:0]     id_q, id_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   rej_q, rej_d;

  logic [IdW-1:0]     win;
  logic               win_found;
  logic               can_accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (win),
    .found (win_found)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    dcnt_d     = dcnt_q;
    gnt_d      = '0;
    busy_d     = busy_q;
    rej_d      = rej_q;
    can_accept = 1'b0;

    unique case (state_q)
      StIdle: begin
        can_accept = 1'b1;
      end
      StWait: begin
        if (dcnt_q == '0) begin
          gnt_d[id_q] = 1'b1;
          state_d     = StGrant;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
        if (enb && (|req) && (rej_q != {CNT_W{1'b1}})) begin
          rej_d = rej_q + CNT_W'(1);
        end
      end
      StGrant: begin
        // Grant cycle ends here; IDLE acceptance is evaluated on the same edge.
        busy_d     = 1'b0;
        state_d    = StIdle;
        can_accept = 1'b1;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    if (can_accept && enb && win_found) begin
      state_d = StWait;
      busy_d  = 1'b1;
      id_d    = win;
      dcnt_d  = DLoad;
      ptr_d   = (win == IdW'(NUM_REQ - 1)) ? '0 : win + IdW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      dcnt_q  <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dcnt_q  <= dcnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      rej_q   <= rej_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign gnt_id  = id_q;
  assign rej_cnt = rej_q;

endmodule

// File: doc/req_gnt_scheduler.md
Name: req_gnt_scheduler

Overview:
- Round-robin request/grant scheduler for a shared resource with fixed grant latency.
- Accepts one request per grant window only while `enb` is high.
- Pulses the matching one-hot `gnt` exactly GNT_DELAY clocks after acceptance, so `req ##GNT_DELAY gnt` holds for every accepted requester.
- Sits between requesting masters and the shared resource; also reports busy state and rejected-request count for assertion-based checking.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- GNT_DELAY, 4, clocks from acceptance edge to grant sampling edge (>=2).
- CNT_W, 8, width of the saturating reject counter.

Ports:
- clk, input, 1, single clock, all logic on posedge.
- rst_n, input, 1, reset: synchronous, active-low.
- enb, input, 1, acceptance enable; sampled only in IDLE.
- req, input, NUM_REQ, per-requester request level.
- gnt, output, NUM_REQ, one-hot grant pulse, registered.
- busy, output, 1, high from acceptance until the grant cycle ends.
- gnt_id, output, $clog2(NUM_REQ), index of the accepted requester; valid while busy.
- rej_cnt, output, CNT_W, saturating count of rejected request cycles.

Behaviour:
- Reset (rst_n low at a posedge):
  - gnt=0, busy=0, gnt_id=0, rej_cnt=0.
  - State=IDLE, RR pointer=0, delay counter=0.
  - Reset asserted mid-WAIT or mid-GRANT aborts the pending grant; no gnt is issued afterwards.
- States:
  - IDLE, WAIT, GRANT.
- IDLE:
  - At edge T, if enb && |req: pick the winner k as the first set req bit scanning from the RR pointer upward with wrap-around.
  - On acceptance: gnt_id=k, busy=1, load the delay counter, go to WAIT. The RR pointer becomes (k+1) mod NUM_REQ.
  - If enb is low, requests are ignored and nothing is counted.
- WAIT:
  - The delay counter decrements each clock.
  - The gnt register sets at edge T+GNT_DELAY-1, so gnt[k] is high during the cycle sampled at edge T+GNT_DELAY. State goes to GRANT.
- GRANT:
  - gnt is high for exactly one cycle.
  - At edge T+GNT_DELAY: gnt clears, busy clears, state returns to IDLE.
  - At that same edge a new acceptance is allowed (IDLE logic is evaluated with the GRANT exit). Peak throughput is one grant per GNT_DELAY clocks.
- Request level after acceptance:
  - req is sampled only at acceptance.
  - Dropping req[k] during WAIT does not cancel the grant.
  - A newly raised req during WAIT/GRANT is not queued.
- Reject counting:
  - Increments on every edge where enb && |req && the request is not accepted (state WAIT or GRANT).
  - Saturates at 2^CNT_W-1 and never wraps.
- Simultaneous requests: exactly one winner per acceptance; all other bits are neither granted nor stored.
- Grant shape: gnt is never multi-hot and never high outside the GRANT state.

Decomposition:
- Shared package `req_gnt_pkg` holds:
  - the state enum type (IDLE/WAIT/GRANT);
  - localparam helper functions for id width, e.g. clog2 wrapper.
- One sub-module, `rr_pick`:
  - combinational round-robin selector;
  - inputs: req vector, pointer;
  - outputs: winner index and a found flag.
- Counters and the FSM stay in the top module.

Test Plan:
- Single request: reset, then enb=1 and req=4'b0001 for one cycle at edge 3 → gnt=4'b0001 sampled at edge 7 only. busy high edges 4..7, gnt_id=0.
- Round-robin: req=4'b1111 held with enb=1 → grants to ids 0,1,2,3,0 at edges 4, 8, 12, 16, 20 from first acceptance at edge 0; rej_cnt increments 3 per window.
- Enable gating: req=4'b0100 held, enb=0 for 10 cycles, then enb=1 at edge 10 → no gnt before edge 14; gnt=4'b0100 at edge 14; rej_cnt=0 before acceptance.
- Request withdrawn: accept req[2] at edge 0, req=0 from edge 1 → gnt[2] still pulses at edge 4, with no second grant.
- Reset mid-operation: accept at edge 0, rst_n low at edge 2 → gnt stays 0 through edge 10; busy=0, rej_cnt=0, and the next acceptance picks from pointer 0.
- Saturation: CNT_W=2, hold req while busy for 10 rejecting cycles → rej_cnt stops at 3.
